// File: rtl/sid_voice_amp.sv
`default_nettype none
// ============================================================================
// Module   : sid_voice_amp
// Brief    : Sequential shift-add multiplier that scales a midscale-offset
//            waveform sample by its envelope, with start/busy/valid handshake.
// Revision : 1.0 - initial release
// ============================================================================
module sid_voice_amp #(
    parameter int WAV_BITS = 12,
    parameter int ENV_BITS = 8,
    parameter int OUT_BITS = WAV_BITS + ENV_BITS
) (
    input  logic                       clk,
    input  logic                       res,
    input  logic                       start,
    input  logic [WAV_BITS-1:0]        wav,
    input  logic [ENV_BITS-1:0]        env,
    output logic                       busy,
    output logic                       valid,
    output logic signed [OUT_BITS-1:0] out,
    output logic                       overrun
);

    localparam int CNT_W = (ENV_BITS > 1) ? $clog2(ENV_BITS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic signed [OUT_BITS-1:0] acc_q, acc_d;
    logic signed [OUT_BITS-1:0] wav_s_q, wav_s_d;
    logic signed [OUT_BITS-1:0] out_q, out_d;
    logic [ENV_BITS-1:0]        env_sh_q, env_sh_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       valid_q, valid_d;
    logic                       overrun_q, overrun_d;

    // Flipping the MSB turns offset-binary into two's complement (wav - midscale).
    logic signed [WAV_BITS-1:0] w_wav_off;
    assign w_wav_off = {~wav[WAV_BITS-1], wav[WAV_BITS-2:0]};

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            wav_s_q   <= '0;
            out_q     <= '0;
            env_sh_q  <= '0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            wav_s_q   <= wav_s_d;
            out_q     <= out_d;
            env_sh_q  <= env_sh_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        wav_s_d   = wav_s_q;
        out_d     = out_q;
        env_sh_d  = env_sh_q;
        cnt_d     = cnt_q;
        valid_d   = 1'b0;
        overrun_d = overrun_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    wav_s_d  = OUT_BITS'(w_wav_off);
                    env_sh_d = env;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (env_sh_q[0]) begin
                    acc_d = acc_q + (wav_s_q << cnt_q);
                end
                env_sh_d = env_sh_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ENV_BITS - 1)) begin
                    state_d = ST_DONE;
                end
                if (start) begin
                    overrun_d = 1'b1;
                end
            end
            ST_DONE: begin
                out_d   = acc_q;
                valid_d = 1'b1;
                state_d = ST_IDLE;
                if (start) begin
                    overrun_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy    = (state_q != ST_IDLE);
    assign valid   = valid_q;
    assign out     = out_q;
    assign overrun = overrun_q;

endmodule
`default_nettype wire
